// File: rtl/mult_pkg.sv
// mult_pkg: shared types and helpers for the shift-add multiplier controller.
//   mult_state_t   - controller state encoding
//   count_width()  - bits needed to hold a shift count of 0..WIDTH
//   SignedMode / UnsignedMode - values for the SIGNED parameter
package mult_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StAdd,
        StShift,
        StHold
    } mult_state_t;

    localparam bit SignedMode   = 1'b1;
    localparam bit UnsignedMode = 1'b0;

    // Count must reach WIDTH itself, hence WIDTH+1 distinct values.
    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_control_if.sv
// mult_control_if: handshake/strobe bundle between the input synchronisers,
// the controller and the multiplier datapath.
//   Run, ClearA_LoadB, M                  - requests and multiplier LSB into the controller
//   Ld_B, Clr_A, Add_En, Sub_En, Shift_En - datapath strobes from the controller
//   Busy, Done, Count                     - status from the controller
// master: the side driving requests (synchronisers/datapath); slave: the controller.
interface mult_control_if
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) ();

    localparam int unsigned CW = count_width(WIDTH);

    logic          Run;
    logic          ClearA_LoadB;
    logic          M;
    logic          Ld_B;
    logic          Clr_A;
    logic          Add_En;
    logic          Sub_En;
    logic          Shift_En;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Count;

    modport master (
        output Run, ClearA_LoadB, M,
        input  Ld_B, Clr_A, Add_En, Sub_En, Shift_En, Busy, Done, Count
    );

    modport slave (
        input  Run, ClearA_LoadB, M,
        output Ld_B, Clr_A, Add_En, Sub_En, Shift_En, Busy, Done, Count
    );

endinterface

// File: rtl/mult_step_counter.sv
// mult_step_counter: counts completed shifts of one multiply.
//   clk_i, rst_ni - clock, asynchronous active-low reset (count -> 0)
//   clr_i         - synchronous clear to 0 (priority over en_i)
//   en_i          - increment, saturating at WIDTH
//   count_o       - current count
//   last_o        - count is WIDTH-1, i.e. the next shift is the final one
module mult_step_counter
    import mult_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CW    = count_width(WIDTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          last_o
);

    logic [CW-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CW'(WIDTH))) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_control.sv
// mult_control: sequencing FSM for a WIDTH-bit shift-add multiplier (A, X, B).
//   Clk, Reset_n - clock, asynchronous active-low reset (all outputs 0 while low)
//   bus          - mult_control_if slave: Run/ClearA_LoadB/M in,
//                  Ld_B/Clr_A/Add_En/Sub_En/Shift_En/Busy/Done/Count out
// WIDTH: operand width, 2..32. SIGNED: final-bit add becomes subtract.
// Sequence: IDLE -> START -> (ADD, SHIFT) x WIDTH -> HOLD -> IDLE once Run drops.
// Outputs are decoded combinationally from the state.
module mult_control
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = SignedMode
) (
    input logic           Clk,
    input logic           Reset_n,
    mult_control_if.slave bus
);

    localparam int unsigned CW = count_width(WIDTH);

    mult_state_t   state_d, state_q;
    logic [CW-1:0] count;
    logic          last_bit;

    mult_step_counter #(
        .WIDTH (WIDTH)
    ) u_step_counter (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .clr_i   (state_q == StStart),
        .en_i    (state_q == StShift),
        .count_o (count),
        .last_o  (last_bit)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.Run) state_d = StStart;
            StStart: state_d = StAdd;
            StAdd:   state_d = StShift;
            StShift: state_d = last_bit ? StHold : StAdd;
            StHold:  if (!bus.Run) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    logic ld_b, clr_a, add_en, sub_en, shift_en, busy, done;

    always_comb begin
        ld_b     = 1'b0;
        clr_a    = 1'b0;
        add_en   = 1'b0;
        sub_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ld_b  = bus.ClearA_LoadB;
                clr_a = bus.ClearA_LoadB;
            end
            StStart: begin
                clr_a = 1'b1;
                busy  = 1'b1;
            end
            StAdd: begin
                busy = 1'b1;
                // Two's-complement weight of the multiplier sign bit is negative.
                if (bus.M) begin
                    if (SIGNED && last_bit) sub_en = 1'b1;
                    else                    add_en = 1'b1;
                end
            end
            StShift: begin
                shift_en = 1'b1;
                busy     = 1'b1;
            end
            StHold:  done = 1'b1;
            default: ;
        endcase
        // The IDLE loads are input-driven, so gate everything during reset.
        if (!Reset_n) begin
            ld_b     = 1'b0;
            clr_a    = 1'b0;
            add_en   = 1'b0;
            sub_en   = 1'b0;
            shift_en = 1'b0;
            busy     = 1'b0;
            done     = 1'b0;
        end
    end

    assign bus.Ld_B     = ld_b;
    assign bus.Clr_A    = clr_a;
    assign bus.Add_En   = add_en;
    assign bus.Sub_En   = sub_en;
    assign bus.Shift_En = shift_en;
    assign bus.Busy     = busy;
    assign bus.Done     = done;
    assign bus.Count    = count;

endmodule
